// File: rtl/uart_pkg.sv
// Shared definitions for the 64-bit UART sender: byte-FSM encoding,
// default clocking constants and the byte-select helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_UART_BPS = 115200;

  // Byte idx of a frame, counted from the most-significant byte.
  function automatic logic [7:0] frame_byte(input logic [63:0] data, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = data << {idx, 3'b000};
    return shifted[63:56];
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serializer for one byte with its own baud counter. A start request
// accepted on the final stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned BPS_CNT = DEF_CLK_FREQ / DEF_UART_BPS
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  output logic        txd_o,
  output logic        done_o,
  output uart_state_e state_o
);

  localparam int unsigned    CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             txd_q, txd_d;
  logic             cnt_end;
  logic             accept;

  assign cnt_end = (cnt_q == CNT_LAST);
  assign done_o  = (state_q == STOP) && cnt_end;
  assign accept  = start_i && ((state_q == IDLE) || done_o);
  assign txd_o   = txd_q;
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    if (state_q != IDLE) begin
      cnt_d = cnt_end ? '0 : cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      START: if (cnt_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (cnt_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_end) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = 3'd0;
      data_d  = data_i;
    end
  end

  // Line level is decided from the next state so it is registered with it.
  always_comb begin
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_send64.sv
// Sends a 64-bit word as eight back-to-back 8N1 bytes, MSB byte first,
// triggered by a rising edge of send_en while the line is idle.
module uart_send64
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned UART_BPS = DEF_UART_BPS
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        send_en,
  input  logic [63:0] send_data,
  output logic        tx_busy,
  output logic        uart_txd
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;

  logic        en_d0_q;
  logic [63:0] data_q, data_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        busy_q, busy_d;

  logic        flag;
  logic        go;
  logic        last_byte;
  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_data;
  uart_state_e byte_state;

  assign flag       = send_en & ~en_d0_q;
  // Requests arriving during a frame, including its final edge, are dropped.
  assign go         = flag && (byte_state == IDLE);
  assign last_byte  = (byte_idx_q == 3'd7);
  assign byte_start = go | (byte_done & ~last_byte);
  assign byte_data  = go ? send_data[63:56] : frame_byte(data_q, byte_idx_q + 3'd1);
  assign tx_busy    = busy_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en_d0_q    <= 1'b1;
      data_q     <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      en_d0_q    <= send_en;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    if (go) begin
      data_d     = send_data;
      byte_idx_d = 3'd0;
      busy_d     = 1'b1;
    end else if (byte_done) begin
      byte_idx_d = byte_idx_q + 3'd1;
      if (last_byte) busy_d = 1'b0;
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .clk     (sys_clk),
    .srst    (sys_rst),
    .start_i (byte_start),
    .data_i  (byte_data),
    .txd_o   (uart_txd),
    .done_o  (byte_done),
    .state_o (byte_state)
  );

endmodule

// File: tb/tb_uart_send64.sv
// Directed bench for uart_send64 at 10 clocks per bit: records whole frames
// cycle by cycle and compares them against hand-written byte tables.
module tb_uart_send64;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int FRAME = 800;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        send_en = 1'b0;
  logic [63:0] send_data = '0;
  logic        tx_busy;
  logic        uart_txd;

  always #5 sys_clk = ~sys_clk;

  uart_send64 #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .send_en   (send_en),
    .send_data (send_data),
    .tx_busy   (tx_busy),
    .uart_txd  (uart_txd)
  );

  typedef struct {
    string             name;
    logic [63:0]       data;
    logic [0:7][7:0]   exp;
  } vec_t;

  vec_t vecs [4];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic txd_s  [0:FRAME];
  logic busy_s [0:FRAME];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic set_vec(input int i, input string name, input logic [63:0] d,
                         input logic [0:7][7:0] e);
    vecs[i].name = name;
    vecs[i].data = d;
    vecs[i].exp  = e;
  endtask

  task automatic pulse(input logic [63:0] d);
    @(posedge sys_clk); #1;
    send_data = d;
    send_en   = 1'b1;
    @(posedge sys_clk); #1;
    send_en   = 1'b0;
  endtask

  // Leaves the caller on the first negedge showing the start bit.
  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (uart_txd !== 1'b0 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk({name, " start"}, {63'd0, uart_txd}, 64'd0);
  endtask

  task automatic record(input int inj_at, input logic [63:0] inj_data);
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) @(negedge sys_clk);
      txd_s[k]  = uart_txd;
      busy_s[k] = tx_busy;
      if (inj_at >= 0 && k == inj_at) begin
        send_data = inj_data;
        send_en   = 1'b1;
      end
      if (inj_at >= 0 && k == inj_at + 3) send_en = 1'b0;
    end
  endtask

  task automatic check_frame(input string name, input logic [0:7][7:0] exp);
    int         wave_err;
    int         busy_hi;
    int         p;
    logic [7:0] got;
    logic [7:0] by;
    logic       e;
    wave_err = 0;
    busy_hi  = 0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) got[i] = txd_s[b*100 + (i+1)*10 + 5];
      chk($sformatf("%s byte%0d", name, b), {56'd0, got}, {56'd0, exp[b]});
    end
    for (int k = 0; k < FRAME; k++) begin
      p  = (k % 100) / 10;
      by = exp[k / 100];
      if (p == 0)      e = 1'b0;
      else if (p == 9) e = 1'b1;
      else             e = by[p-1];
      if (txd_s[k] !== e) wave_err++;
      if (busy_s[k] === 1'b1) busy_hi++;
    end
    chk({name, " waveform errors"}, 64'(wave_err), 64'd0);
    chk({name, " busy cycles"}, 64'(busy_hi), 64'd800);
    chk({name, " txd/busy after frame"}, {62'd0, txd_s[FRAME], busy_s[FRAME]}, 64'b10);
  endtask

  task automatic check_idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    set_vec(0, "basic", 64'h0123456789ABCDEF,
            {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF});
    set_vec(1, "zeros", 64'h0000000000000000,
            {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    set_vec(2, "ones",  64'hFFFFFFFFFFFFFFFF,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    set_vec(3, "mixed", 64'h80017E3C55AAC3F0,
            {8'h80, 8'h01, 8'h7E, 8'h3C, 8'h55, 8'hAA, 8'hC3, 8'hF0});

    // Reset state
    repeat (5) @(negedge sys_clk);
    chk("reset txd", {63'd0, uart_txd}, 64'd1);
    chk("reset busy", {63'd0, tx_busy}, 64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check_idle("idle after reset", 20);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      pulse(vecs[v].data);
      wait_start(vecs[v].name);
      record(-1, '0);
      check_frame(vecs[v].name, vecs[v].exp);
      $display("frame %s data=%h done", vecs[v].name, vecs[v].data);
    end

    // Second request at cycle 300 must be dropped, not queued
    pulse(vecs[0].data);
    wait_start("busy_rej");
    record(300, 64'hFFFFFFFFFFFFFFFF);
    check_frame("busy_rej", vecs[0].exp);
    check_idle("busy_rej no second frame", 900);
    $display("busy rejection sequence done");

    // send_en held high: one frame only, then a fresh edge sends again
    @(posedge sys_clk); #1;
    send_data = vecs[3].data;
    send_en   = 1'b1;
    wait_start("level");
    record(-1, '0);
    check_frame("level", vecs[3].exp);
    check_idle("level hold no repeat", 1150);
    @(posedge sys_clk); #1;
    send_en = 1'b0;
    repeat (3) @(posedge sys_clk);
    pulse(vecs[0].data);
    wait_start("level re-edge");
    record(-1, '0);
    check_frame("level re-edge", vecs[0].exp);
    $display("level hold sequence done");

    // Reset at cycle 415 of a frame aborts it
    pulse(vecs[3].data);
    wait_start("rst_mid");
    for (int k = 1; k <= 415; k++) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid txd/busy", {62'd0, uart_txd, tx_busy}, 64'b10);
    sys_rst = 1'b0;
    check_idle("rst_mid stays idle", 200);
    pulse(vecs[0].data);
    wait_start("after rst");
    record(-1, '0);
    check_frame("after rst", vecs[0].exp);
    $display("reset mid-frame sequence done");

    // Request held high across reset release must not start a frame
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    send_en = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check_idle("rst with request high", 300);
    @(posedge sys_clk); #1;
    send_en = 1'b0;
    repeat (3) @(posedge sys_clk);
    $display("reset with request high sequence done");

    // Back-to-back boundary frames, second edge on the first non-busy cycle
    pulse(vecs[1].data);
    wait_start("b2b zeros");
    record(FRAME, vecs[2].data);
    check_frame("b2b zeros", vecs[1].exp);
    wait_start("b2b ones");
    send_en = 1'b0;
    record(-1, '0);
    check_frame("b2b ones", vecs[2].exp);
    $display("back-to-back boundary sequence done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
